// File: rtl/switch_color_conditioner_if.sv
// Colour-request bus between the switch conditioner and its environment.
// The slave side is the conditioner; the master side drives switches and vsync.
interface switch_color_conditioner_if;
   logic [11:0] sw;
   logic        vsync_start;
   logic [11:0] color;
   logic        color_update;
   logic        pending;

   modport slave (
      input  sw,
      input  vsync_start,
      output color,
      output color_update,
      output pending
   );

   modport master (
      output sw,
      output vsync_start,
      input  color,
      input  color_update,
      input  pending
   );
endinterface

// File: rtl/switch_color_conditioner.sv
// Synchronizes and debounces the colour switches, then commits the settled
// colour only at the start of vertical blanking so the picture never tears.
module switch_color_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                        clk,
   input  logic                        reset,
   switch_color_conditioner_if.slave   bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, PENDING} state_t;

   state_t          state, state_next;
   logic [11:0]     sync1, sw_s;
   logic [11:0]     stable, cand, color;
   logic [CW-1:0]   cnt;
   logic            color_update;
   logic            load, inc, accept, commit;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sw_s  <= '0;
      end else begin
         sync1 <= bus.sw;
         sw_s  <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sw_s != stable) state_next = SETTLE;
         SETTLE:  if (sw_s == cand && cnt == CNT_LAST)
                     state_next = (cand != color) ? PENDING : IDLE;
         PENDING: begin
            if (sw_s != stable)        state_next = SETTLE;
            else if (bus.vsync_start)  state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath strobes; a commit and a fresh settle may coincide in PENDING.
   always_comb begin
      load   = 1'b0;
      inc    = 1'b0;
      accept = 1'b0;
      commit = 1'b0;
      case (state)
         IDLE:    load = (sw_s != stable);
         SETTLE: begin
            if (sw_s != cand)         load   = 1'b1;
            else if (cnt == CNT_LAST) accept = 1'b1;
            else                      inc    = 1'b1;
         end
         PENDING: begin
            commit = bus.vsync_start;
            load   = (sw_s != stable);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable       <= '0;
         cand         <= '0;
         cnt          <= '0;
         color        <= '0;
         color_update <= 1'b0;
      end else begin
         color_update <= commit;
         if (commit) color <= stable;
         if (accept) stable <= cand;
         if (load) begin
            cand <= sw_s;
            cnt  <= '0;
         end else if (inc) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bus.color        = color;
   assign bus.color_update = color_update;
   assign bus.pending      = (state == PENDING);
endmodule

// File: tb/tb_switch_color_conditioner.sv
// Self-checking bench: fixed vector table, corner-case sequences and random
// stimulus compared against a timestamp-based reference model.
module tb_switch_color_conditioner;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   switch_color_conditioner_if bus();

   switch_color_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a settle window is timed by the edge number it began on.
   int          n = 0;
   int          m_start;
   logic [11:0] m_s1, m_s2, m_stable, m_cand, m_color;
   logic        m_settling, m_queued, m_upd;

   typedef struct {
      logic        rst;
      logic [11:0] sw;
      logic        vs;
      logic [11:0] color;
      logic        upd;
      logic        pend;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, input logic [11:0] s, input logic v,
                      input logic [11:0] c, input logic u, input logic p);
      vec_t e;
      e.rst = r; e.sw = s; e.vs = v; e.color = c; e.upd = u; e.pend = p;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic [11:0] x, input logic vs);
      logic [11:0] s;
      s = m_s2;
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_cand = 0; m_color = 0;
         m_settling = 0; m_queued = 0; m_upd = 0; m_start = n;
      end else begin
         m_upd = 0;
         if (m_queued) begin
            if (vs) begin m_color = m_stable; m_upd = 1; end
            if (vs || s != m_stable) m_queued = 0;
            if (s != m_stable) begin m_settling = 1; m_cand = s; m_start = n; end
         end else if (m_settling) begin
            if (s != m_cand) begin
               m_cand = s; m_start = n;
            end else if (n - m_start == D) begin
               m_stable = m_cand; m_settling = 0; m_queued = (m_cand != m_color);
            end
         end else if (s != m_stable) begin
            m_settling = 1; m_cand = s; m_start = n;
         end
         m_s2 = m_s1;
         m_s1 = x;
      end
   endtask

   // One clock: drive, advance model at the edge, compare 1 time unit later.
   task automatic step(input logic r, input logic [11:0] s, input logic v);
      reset = r; bus.sw = s; bus.vsync_start = v;
      @(posedge clk);
      n++;
      model_edge(r, s, v);
      #1;
      chk("color", bus.color, m_color);
      chk("color_update", {11'd0, bus.color_update}, {11'd0, m_upd});
      chk("pending", {11'd0, bus.pending}, {11'd0, m_queued});
   endtask

   task automatic wait_queued(input logic [11:0] s, input int max);
      int k = 0;
      while (!m_queued && k < max) begin
         step(1'b0, s, 1'b0);
         k++;
      end
      if (!m_queued) begin
         n_vec++; n_err++;
         $display("FAIL wait_pending: got timeout expected pending within %0d cycles", max);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] pool [6];
      logic [11:0] cur;
      vec_t e;
      pool[0] = 12'h000; pool[1] = 12'hF00; pool[2] = 12'h0F0;
      pool[3] = 12'h00F; pool[4] = 12'hABC; pool[5] = 12'h123;

      reset = 1'b1; bus.sw = '0; bus.vsync_start = 1'b0;
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_cand = 0; m_color = 0;
      m_settling = 0; m_queued = 0; m_upd = 0; m_start = 0;

      // Debounce latency, vsync ignored while settling, back-to-back vsync,
      // then reset colliding with a vsync while a colour is queued.
      add(1, 12'h000, 0, 12'h000, 0, 0);
      add(0, 12'hF00, 0, 12'h000, 0, 0);
      add(0, 12'hF00, 0, 12'h000, 0, 0);
      add(0, 12'hF00, 0, 12'h000, 0, 0);
      add(0, 12'hF00, 1, 12'h000, 0, 0);
      add(0, 12'hF00, 0, 12'h000, 0, 0);
      add(0, 12'hF00, 0, 12'h000, 0, 0);
      add(0, 12'hF00, 0, 12'h000, 0, 1);
      add(0, 12'hF00, 1, 12'hF00, 1, 0);
      add(0, 12'hF00, 1, 12'hF00, 0, 0);
      add(0, 12'hF00, 0, 12'hF00, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 12'hABC, 0, 12'hF00, 0, 0);
      add(0, 12'hABC, 0, 12'hF00, 0, 1);
      add(1, 12'hABC, 1, 12'h000, 0, 0);
      add(0, 12'hABC, 0, 12'h000, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         e = tbl[i];
         step(e.rst, e.sw, e.vs);
         chk("tbl_color", bus.color, e.color);
         chk("tbl_update", {11'd0, bus.color_update}, {11'd0, e.upd});
         chk("tbl_pending", {11'd0, bus.pending}, {11'd0, e.pend});
      end

      // Fast toggling never settles; the held value then needs a full quiet window.
      step(1'b1, 12'h000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, (i % 2) ? 12'h000 : 12'h0F0, 1'b0);
         step(1'b0, (i % 2) ? 12'h000 : 12'h0F0, 1'b0);
         chk("toggle_pending", {11'd0, bus.pending}, 12'd0);
      end
      chk("toggle_color", bus.color, 12'h000);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 12'h0F0, 1'b0);
         if (i == 5) chk("quiet_pending_early", {11'd0, bus.pending}, 12'd0);
      end
      chk("quiet_pending", {11'd0, bus.pending}, 12'd1);
      chk("quiet_color_held", bus.color, 12'h000);
      step(1'b0, 12'h0F0, 1'b1);
      chk("quiet_commit", bus.color, 12'h0F0);

      // A new request while queued abandons the queued colour.
      step(1'b1, 12'h000, 1'b0);
      wait_queued(12'h00F, 12);
      step(1'b0, 12'h0FF, 1'b0);
      step(1'b0, 12'h0FF, 1'b0);
      step(1'b0, 12'h0FF, 1'b0);
      chk("abandon_pending", {11'd0, bus.pending}, 12'd0);
      step(1'b0, 12'h0FF, 1'b1);
      chk("abandon_no_update", {11'd0, bus.color_update}, 12'd0);
      chk("abandon_color", bus.color, 12'h000);
      wait_queued(12'h0FF, 12);
      step(1'b0, 12'h0FF, 1'b1);
      chk("abandon_commit", bus.color, 12'h0FF);

      // Bounce away from and back to the displayed colour: no commit.
      wait_queued(12'h00F, 12);
      step(1'b0, 12'h00F, 1'b1);
      chk("bounce_setup", bus.color, 12'h00F);
      step(1'b0, 12'h123, 1'b0);
      step(1'b0, 12'h123, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 12'h00F, (i % 3) == 0);
         chk("bounce_pending", {11'd0, bus.pending}, 12'd0);
         chk("bounce_update", {11'd0, bus.color_update}, 12'd0);
      end
      chk("bounce_color", bus.color, 12'h00F);

      // Random switch activity, vsync strobes and occasional resets.
      cur = 12'h000;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) cur = pool[$urandom_range(0, 5)];
         step($urandom_range(0, 199) == 0, cur, $urandom_range(0, 7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/switch_color_conditioner.md
SWITCH_COLOR_CONDITIONER -- requirements
Module: switch_color_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive pixel-clock cycles a synchronized switch value must hold before it is accepted (10 ms at 100 MHz); legal range is 2 or more.
REQ-002 Port: clk  input  1  system clock; all logic is on its rising edge.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: sw  input  12  raw asynchronous slide-switch colour request {R[3:0], G[3:0], B[3:0]}.
REQ-005 Port: vsync_start  input  1  single-cycle strobe from the VGA timing stage at the first cycle of vertical blanking.
REQ-006 Port: color  output  12  tear-free colour word feeding the rgb drive register; it is registered.
REQ-007 Port: color_update  output  1  single-cycle pulse, registered, asserted in the cycle in which color takes a new value.
REQ-008 Port: pending  output  1  high while a debounced colour awaits the next vsync_start.

Function
REQ-009 sw SHALL pass through a 2-flop synchronizer, giving sw_s; sw_s reflects sw 2 cycles later.
REQ-010 Internal registers SHALL be: stable[11:0] (last debounced value), cand[11:0] (candidate value), cnt (width clog2(DEBOUNCE_CYCLES)), and a state register with states IDLE, SETTLE, PENDING.
REQ-011 IDLE: if sw_s != stable, the block SHALL set cand <= sw_s and cnt <= 0, and go to SETTLE; otherwise it stays in IDLE.
REQ-012 SETTLE, when sw_s != cand: the block SHALL set cand <= sw_s and cnt <= 0 (restart), and remain in SETTLE.
REQ-013 SETTLE, when sw_s == cand and cnt == DEBOUNCE_CYCLES-1: the block SHALL set stable <= cand, then go to PENDING if cand != color, else go to IDLE with no update.
REQ-014 SETTLE, when sw_s == cand otherwise: the block SHALL set cnt <= cnt+1, with no wrap possible.
REQ-015 Consequence: stable updates exactly DEBOUNCE_CYCLES cycles after the last SETTLE entry or restart.
REQ-016 A bounce back to the value already in stable during SETTLE SHALL still restart the count; the later commit then yields stable unchanged.
REQ-017 PENDING with vsync_start == 1: the block SHALL set color <= stable and color_update <= 1 on the next edge.
REQ-018 After that commit, the block SHALL go to SETTLE (loading cand/cnt as in REQ-011) if sw_s != stable, else go to IDLE.
REQ-019 PENDING with vsync_start == 0 and sw_s != stable: the block SHALL go to SETTLE per REQ-011; the pending commit is abandoned and pending drops.
REQ-020 vsync_start in IDLE or SETTLE SHALL have no effect.
REQ-021 color SHALL change only on a vsync_start accepted in PENDING; it never changes mid-frame.
REQ-022 color_update SHALL be high for exactly one cycle per commit and SHALL never pulse when the committed value equals the previous color.
REQ-023 pending SHALL be combinationally (state == PENDING).
REQ-024 Back-to-back vsync_start strobes on consecutive cycles SHALL produce at most one commit.

Reset
REQ-025 With reset high at a clk edge, the block SHALL clear the sync flops, stable, cand, cnt and color to 0, set color_update to 0 and state to IDLE; pending then reads 0.
REQ-026 Reset SHALL take priority over every transition, including a simultaneous vsync_start in PENDING; no commit occurs.
REQ-027 On the first cycle after reset deasserts, the block SHALL behave as IDLE with all-zero history; a nonzero sw re-enters SETTLE after 2 synchronizer cycles.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Scenario: after reset, hold sw = 12'hF00 -> pending rises 2+1+4 cycles after the change; first vsync_start then gives color = 12'hF00 with one color_update pulse on the next edge.
REQ-029 Scenario: toggle sw between 12'h0F0 and 12'h000 every 2 cycles for 20 cycles, then hold 12'h0F0 -> no stable update during toggling; pending only after 4 quiet cycles; color stays 0 until vsync_start.
REQ-030 Scenario: in PENDING with 12'h00F, change sw to 12'h0FF before vsync_start -> pending drops, the next vsync_start causes no update, and 12'h0FF commits on the following vsync_start.
REQ-031 Scenario: set sw to the current color value (12'h00F to 12'h123 and back to 12'h00F within debounce) -> stable re-settles to 12'h00F, no PENDING, no color_update.
REQ-032 Scenario: assert reset in the same cycle as vsync_start while pending (color 12'hABC queued) -> color = 0, color_update = 0, state IDLE.
REQ-033 Scenario: vsync_start on two consecutive cycles in PENDING -> exactly one color_update pulse.
